// File: rtl/note_sequencer.sv
// Step sequencer driving the saw oscillator's frequency word and gate from a programmable pattern.
// Define SEQ_LOOP_EN to repeat the pattern until stop instead of returning to IDLE at pattern end.
module note_sequencer #(
   parameter int unsigned STEPS     = 16,
   parameter int unsigned TICK_DIV  = 12000,
   parameter int unsigned GAP_TICKS = 2
) (
   input  logic                     clk12MHz,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(STEPS)-1:0] wr_addr,
   input  logic [15:0]              wr_freq,
   input  logic [7:0]               wr_dur,
   input  logic [$clog2(STEPS):0]   length,
   input  logic                     start,
   input  logic                     stop,
   output logic [15:0]              freq,
   output logic                     gate,
   output logic [$clog2(STEPS)-1:0] step_idx,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned LW = $clog2(STEPS);
   localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [LW:0]   STEPS_W    = (LW+1)'(STEPS);
   localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
   localparam logic [7:0]    GAP_LAST   = 8'(GAP_TICKS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, NOTE, GAP, ADV} state_t;

   typedef struct packed {
      logic [15:0] freq;
      logic [7:0]  dur;
   } slot_t;

   slot_t mem [STEPS];

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [7:0]    tcnt_q, tcnt_d;
   logic [7:0]    dur_q, dur_d;
   logic [LW:0]   len_q, len_d;
   logic [15:0]   freq_d;
   logic          gate_d;
   logic [LW-1:0] step_d;
   logic          busy_d;
   logic          done_d;

   slot_t         rd_slot_c;
   logic          tick_c;
   logic          last_c;

   assign rd_slot_c = mem[step_idx];
   assign tick_c    = (div_q == DIV_LAST);
   assign last_c    = ((LW+1)'(step_idx) == (len_q - (LW+1)'(1)));

   // Pattern memory: not reset, writable in any state
   always_ff @(posedge clk12MHz) begin
      if (wr_en) mem[wr_addr] <= slot_t'({wr_freq, wr_dur});
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      div_d   = '0;
      tcnt_d  = tcnt_q;
      dur_d   = dur_q;
      len_d   = len_q;
      freq_d  = freq;
      gate_d  = gate;
      step_d  = step_idx;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && (length != '0)) begin
               len_d   = (length > STEPS_W) ? STEPS_W : length;
               step_d  = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            tcnt_d = '0;
            if (rd_slot_c.dur == 8'd0) begin
               done_d  = last_c;
               state_d = ADV;
            end else begin
               freq_d  = rd_slot_c.freq;
               gate_d  = (rd_slot_c.freq != 16'd0);
               dur_d   = rd_slot_c.dur;
               state_d = NOTE;
            end
         end
         NOTE: begin
            div_d = tick_c ? '0 : div_q + DW'(1);
            if (tick_c) begin
               if (tcnt_q == dur_q - 8'd1) begin
                  tcnt_d  = '0;
                  gate_d  = 1'b0;
                  state_d = GAP;
               end else begin
                  tcnt_d = tcnt_q + 8'd1;
               end
            end
         end
         GAP: begin
            div_d = tick_c ? '0 : div_q + DW'(1);
            if (tick_c) begin
               if (tcnt_q == GAP_LAST) begin
                  tcnt_d  = '0;
                  done_d  = last_c;
                  state_d = ADV;
               end else begin
                  tcnt_d = tcnt_q + 8'd1;
               end
            end
         end
         ADV: begin
            if (last_c) begin
`ifdef SEQ_LOOP_EN
               step_d  = '0;
               state_d = LOAD;
`else
               step_d  = '0;
               freq_d  = 16'd0;
               gate_d  = 1'b0;
               state_d = IDLE;
`endif
            end else begin
               step_d  = step_idx + LW'(1);
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides everything, including a pending end-of-pattern pulse
      if (stop) begin
         state_d = IDLE;
         div_d   = '0;
         tcnt_d  = '0;
         freq_d  = 16'd0;
         gate_d  = 1'b0;
         step_d  = '0;
         done_d  = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk12MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         div_q    <= '0;
         tcnt_q   <= '0;
         dur_q    <= '0;
         len_q    <= '0;
         freq     <= '0;
         gate     <= 1'b0;
         step_idx <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         tcnt_q   <= tcnt_d;
         dur_q    <= dur_d;
         len_q    <= len_d;
         freq     <= freq_d;
         gate     <= gate_d;
         step_idx <= step_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, GAP_TICKS=1, STEPS=16.
module tb_note_sequencer;

   logic        clk12MHz;
   logic        rst_n;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_freq;
   logic [7:0]  wr_dur;
   logic [4:0]  length;
   logic        start;
   logic        stop;
   logic [15:0] freq;
   logic        gate;
   logic [3:0]  step_idx;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   note_sequencer #(.STEPS(16), .TICK_DIV(4), .GAP_TICKS(1)) dut (
      .clk12MHz(clk12MHz), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_freq(wr_freq), .wr_dur(wr_dur), .length(length), .start(start),
      .stop(stop), .freq(freq), .gate(gate), .step_idx(step_idx),
      .busy(busy), .done(done)
   );

   initial clk12MHz = 1'b0;
   always #5 clk12MHz = ~clk12MHz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk12MHz);
      #1;
   endtask

   task automatic write_slot(input int a, input int f, input int d);
      wr_en   = 1'b1;
      wr_addr = 4'(a);
      wr_freq = 16'(f);
      wr_dur  = 8'(d);
      tick();
      wr_en   = 1'b0;
   endtask

   // Start pulse during cycle 0; returns positioned in cycle 1
   task automatic start_pat(input int len);
      length = 5'(len);
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   initial begin
      int dcnt;
      int dcyc;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_dur = '0;
      length = '0; start = 1'b0; stop = 1'b0;
      #1;
      chk("rst_freq", 32'(freq), 0);
      chk("rst_gate", 32'(gate), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_step", 32'(step_idx), 0);
      chk("rst_done", 32'(done), 0);
      #12 rst_n = 1'b1;
      tick();

      // 1: single step {440,3}
      write_slot(0, 440, 3);
      start_pat(1);
      for (int c = 1; c <= 20; c++) begin
         chk($sformatf("t1_gate_c%0d", c), 32'(gate), 32'((c >= 2) && (c <= 13)));
         chk($sformatf("t1_done_c%0d", c), 32'(done), 32'(c == 18));
         chk($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c <= 18));
         chk($sformatf("t1_freq_c%0d", c), 32'(freq), ((c >= 2) && (c <= 18)) ? 440 : 0);
         tick();
      end

      // 2: play, rest, skip, play
      write_slot(0, 440, 2);
      write_slot(1, 0, 2);
      write_slot(2, 1, 0);
      write_slot(3, 880, 1);
      start_pat(4);
      dcnt = 0;
      for (int c = 1; c <= 44; c++) begin
         int ef, eg, es;
         ef = (c >= 2 && c <= 15) ? 440 : (c >= 32 && c <= 40) ? 880 : 0;
         eg = ((c >= 2 && c <= 9) || (c >= 32 && c <= 35)) ? 1 : 0;
         es = (c >= 15 && c <= 28) ? 1 : (c >= 29 && c <= 30) ? 2 : (c >= 31 && c <= 40) ? 3 : 0;
         chk($sformatf("t2_freq_c%0d", c), 32'(freq), 32'(ef));
         chk($sformatf("t2_gate_c%0d", c), 32'(gate), 32'(eg));
         chk($sformatf("t2_step_c%0d", c), 32'(step_idx), 32'(es));
         chk($sformatf("t2_done_c%0d", c), 32'(done), 32'(c == 40));
         if (done) dcnt++;
         tick();
      end
      chk("t2_done_count", 32'(dcnt), 1);

      // 3: stop mid-NOTE, then stop with simultaneous start
      write_slot(0, 440, 3);
      start_pat(1);
      repeat (5) tick();
      chk("t3_gate_before_stop", 32'(gate), 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t3_gate", 32'(gate), 0);
      chk("t3_freq", 32'(freq), 0);
      chk("t3_busy", 32'(busy), 0);
      chk("t3_step", 32'(step_idx), 0);
      dcnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (done) dcnt++;
         tick();
      end
      chk("t3_no_done", 32'(dcnt), 0);
      length = 5'd1; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("t3_stop_start_busy", 32'(busy), 0);
      repeat (3) tick();
      chk("t3_stop_start_busy_later", 32'(busy), 0);

      // 4a: zero length is ignored
      start_pat(0);
      chk("t4_len0_busy", 32'(busy), 0);
      repeat (2) tick();
      chk("t4_len0_busy_later", 32'(busy), 0);

      // 4b: second start while busy leaves timing unchanged
      start_pat(1);
      dcyc = -1;
      for (int c = 1; c <= 25; c++) begin
         if (done && dcyc < 0) dcyc = c;
         length = 5'd1;
         start  = (c == 5);
         tick();
      end
      start = 1'b0;
      chk("t4_restart_done_cycle", 32'(dcyc), 18);

      // 4c: length above STEPS clamps to 16 steps of 10 cycles each
      for (int k = 0; k < 16; k++) write_slot(k, 100 + k, 1);
      start_pat(20);
      dcnt = 0; dcyc = -1;
      for (int c = 1; c <= 170; c++) begin
         if (c == 151) chk("t4_clamp_step151", 32'(step_idx), 15);
         if (c == 152) chk("t4_clamp_freq152", 32'(freq), 115);
         if (c == 161) chk("t4_clamp_busy161", 32'(busy), 0);
         if (done) begin dcnt++; dcyc = c; end
         tick();
      end
      chk("t4_clamp_done_count", 32'(dcnt), 1);
      chk("t4_clamp_done_cycle", 32'(dcyc), 160);

`ifdef SEQ_LOOP_EN
      // 5: looping two-step pattern
      write_slot(0, 440, 1);
      write_slot(1, 880, 1);
      start_pat(2);
      for (int c = 1; c <= 44; c++) begin
         int es;
         es = ((c >= 11 && c <= 20) || (c >= 31 && c <= 40)) ? 1 : 0;
         chk($sformatf("t5_step_c%0d", c), 32'(step_idx), 32'(es));
         chk($sformatf("t5_done_c%0d", c), 32'(done), 32'(c == 20 || c == 40));
         if (c % 10 == 0) chk($sformatf("t5_gate_adv_c%0d", c), 32'(gate), 0);
         tick();
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t5_stop_busy", 32'(busy), 0);
`endif

      // 6a: async reset mid-GAP takes effect between clock edges
      write_slot(0, 440, 3);
      start_pat(1);
      repeat (14) tick();
      chk("t6_in_gap_gate", 32'(gate), 0);
      chk("t6_in_gap_busy", 32'(busy), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_rst_freq", 32'(freq), 0);
      chk("t6_rst_gate", 32'(gate), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_step", 32'(step_idx), 0);
      chk("t6_rst_done", 32'(done), 0);
      #2 rst_n = 1'b1;
      tick();
      chk("t6_idle_after_rst", 32'(busy), 0);

      // 6b: write to the slot being read in LOAD returns old data
      start_pat(1);
      wr_en = 1'b1; wr_addr = 4'd0; wr_freq = 16'd660; wr_dur = 8'd3;
      tick();
      wr_en = 1'b0;
      chk("t6_old_freq", 32'(freq), 440);
      chk("t6_old_gate", 32'(gate), 1);
      repeat (20) tick();
      chk("t6_idle_again", 32'(busy), 0);
      start_pat(1);
      tick();
      chk("t6_new_freq", 32'(freq), 660);
      chk("t6_new_gate", 32'(gate), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Step sequencer that plays a programmable pattern of notes by driving the frequency word and gate of the 12-bit saw oscillator voice. It runs on the 12 MHz system clock.
- Each step holds a frequency word and a duration in ms ticks. The sequencer plays the note with the gate high, then a fixed gap with the gate low, then advances to the next step.
- It sits between the control/UART register layer, which loads the pattern and issues start/stop, and the oscillator `freq` input.

Parameters:
- STEPS, 16, number of pattern slots; power of 2, 2..256.
- TICK_DIV, 12000, clk12MHz cycles per duration tick (1 ms).
- GAP_TICKS, 2, gate-low ticks between steps; range 1..255.

Ports:
- clk12MHz  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  pattern write strobe.
- wr_addr  in  log2(STEPS)  slot to write.
- wr_freq  in  16  frequency word for the slot; 0 = rest.
- wr_dur  in  8  note length in ticks; 0 = skip slot.
- length  in  log2(STEPS)+1  steps to play, sampled at start.
- start  in  1  single-cycle start pulse.
- stop  in  1  single-cycle abort pulse.
- freq  out  16  frequency word to oscillator.
- gate  out  1  note-on.
- step_idx  out  log2(STEPS)  current step.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at pattern end.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; freq=0, gate=0, step_idx=0, busy=0, done=0.
  - Tick divider and duration counters are cleared.
  - Pattern memory is not reset.
- Memory:
  - STEPS x 24-bit entries, synchronous write on wr_en, allowed in any state.
  - Registered read happens in LOAD. A write to the slot being read in the same cycle returns the old data.
- Tick divider:
  - Counts 0..TICK_DIV-1 and clears on every state entry.
  - tick = divider at TICK_DIV-1.
- State IDLE:
  - start with length != 0: latch len_q = min(length, STEPS), step_idx=0, go to LOAD.
  - start with length == 0: ignored.
  - start while not IDLE: ignored.
- State LOAD (1 cycle): read slot step_idx.
  - dur == 0: go to ADV.
  - Otherwise: go to NOTE.
- State NOTE:
  - freq = slot freq, and it is held through GAP.
  - gate = 1 if slot freq != 0, else 0 (rest).
  - Exactly dur*TICK_DIV cycles, then go to GAP.
- State GAP:
  - gate = 0, freq held.
  - Exactly GAP_TICKS*TICK_DIV cycles, then go to ADV.
- State ADV (1 cycle):
  - If step_idx == len_q-1: end of pattern (see Optional Feature).
  - Otherwise: step_idx+1, go to LOAD.
- Latency:
  - start at cycle 0 → LOAD at cycle 1 → NOTE with gate=1 and freq valid at cycle 2.
  - Per played step: 1 (LOAD) + dur*TICK_DIV + GAP_TICKS*TICK_DIV + 1 (ADV) cycles.
  - Per skipped step: 2 cycles.
- stop:
  - Highest priority; wins over a simultaneous start.
  - From any state, next cycle: IDLE, gate=0, freq=0, step_idx=0, done not pulsed.
- step_idx width wraps naturally; len_q prevents overrun.
- Async reset mid-pattern: outputs return immediately to their reset values; the pattern restarts only on a new start.

Optional Feature:
- SEQ_LOOP_EN defined:
  - At pattern end, ADV sets step_idx=0, pulses done for 1 cycle, and goes to LOAD.
  - Playback repeats until stop.
- SEQ_LOOP_EN not defined:
  - At pattern end, ADV pulses done for 1 cycle and goes to IDLE with freq=0, gate=0, step_idx=0.

Test Plan:
1. Single step:
   - Setup: TICK_DIV=4, GAP_TICKS=1; write slot0 = {440, 3}; length=1; start at cycle 0.
   - Expect: gate high cycles 2-13, low cycles 14-17; done at cycle 18; busy low from cycle 19.
2. Multi-step with skip and rest:
   - Setup: slots {440,2}, {0,2}, {1,0}, {880,1}; length=4.
   - Expect: freq 440 with gate high; then rest with freq=0 and gate low for 8 cycles; slot2 skipped in 2 cycles; then 880; exactly one done pulse.
3. Stop mid-NOTE:
   - Stimulus: stop at cycle 6 of test 1.
   - Expect: at cycle 7 gate=0, freq=0, busy=0; no done pulse.
   - Stimulus: stop and start asserted in the same cycle.
   - Expect: remains IDLE.
4. Start edge cases:
   - Stimulus: start with length=0.
   - Expect: busy stays 0.
   - Stimulus: length=20 with STEPS=16.
   - Expect: plays 16 steps.
   - Stimulus: second start while busy.
   - Expect: ignored; timing unchanged.
5. SEQ_LOOP_EN with length=2:
   - Expect: done pulses every period, step_idx sequence 0,1,0,1; gate never held high across ADV.
6. Async reset and memory write:
   - Stimulus: drop rst_n mid-GAP.
   - Expect: all outputs 0 immediately, regardless of clock.
   - Stimulus: write the slot being read during LOAD.
   - Expect: old value plays; new value plays on the next pass.
